// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU with iterative mul/div.
//   alu_op_e   : 4-bit operation code {md, alusel}
//   md_state_e : sequencer states for the iterative unit
//   md_ctx_t   : per-operation context captured when a mul/div is accepted
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SLL    = 4'b0001,
        OP_SUB    = 4'b0010,
        OP_SRA    = 4'b0011,
        OP_XOR    = 4'b0100,
        OP_SRL    = 4'b0101,
        OP_OR     = 4'b0110,
        OP_AND    = 4'b0111,
        OP_MUL    = 4'b1000,
        OP_MULH   = 4'b1001,
        OP_MULHSU = 4'b1010,
        OP_MULHU  = 4'b1011,
        OP_DIV    = 4'b1100,
        OP_DIVU   = 4'b1101,
        OP_REM    = 4'b1110,
        OP_REMU   = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } md_state_e;

    // Captured at accept so the FIN fixup does not depend on live inputs.
    typedef struct packed {
        alu_op_e op;
        logic    a_neg;   // operand1 was negated to its magnitude
        logic    b_neg;   // operand2 was negated to its magnitude
        logic    div0;    // divisor was zero
        logic    ovf;     // signed MIN / -1
    } md_ctx_t;

    // operand1 is treated as signed for these ops
    function automatic logic op_a_signed(input alu_op_e o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    // operand2 is treated as signed for these ops
    function automatic logic op_b_signed(input alu_op_e o);
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one-bit-per-cycle unsigned multiply / restoring divide datapath.
//   clk, rst_n : clock, async active-low reset
//   start      : load magnitudes, clear accumulator, load iteration counter
//   step       : commit one iteration (acc/lo <= nxt_hi/nxt_lo, cnt--)
//   is_div     : select divide step (1) or multiply step (0)
//   a_in, b_in : multiplier/dividend and multiplicand/divisor magnitudes
//   cnt        : remaining registered iterations
//   nxt_hi/lo  : combinational result of the next iteration. After the final
//                step {hi,lo} is the 2*XLEN product, or hi=remainder, lo=quotient.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      step,
    input  logic                      is_div,
    input  logic [XLEN-1:0]           a_in,
    input  logic [XLEN-1:0]           b_in,
    output logic [$clog2(XLEN)-1:0]   cnt,
    output logic [XLEN-1:0]           nxt_hi,
    output logic [XLEN-1:0]           nxt_lo
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] acc_q, lo_q, b_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    always_comb begin
        // multiply: conditionally add multiplicand, shift {carry,acc,lo} right
        mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
        // divide: shift next dividend bit into remainder, trial-subtract
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        nxt_hi    = mul_sum[XLEN:1];
        nxt_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        if (is_div) begin
            if (!div_diff[XLEN]) begin
                nxt_hi = div_diff[XLEN-1:0];
                nxt_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[XLEN-1:0];
                nxt_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            acc_q <= '0;
            lo_q  <= a_in;
            b_q   <= b_in;
            // XLEN-1 registered steps; the last step is taken combinationally in FIN
            cnt_q <= CW'(XLEN - 1);
        end else if (step) begin
            acc_q <= nxt_hi;
            lo_q  <= nxt_lo;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alu_md_seq.sv
// alu_md_seq: EX-stage ALU with integrated iterative multiply/divide.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operation handshake (in_ready only in IDLE with a free output slot)
//   op                  : {md, alusel}, see alu_op_e
//   operand1, operand2  : rs1 / rs2 values
//   nop                 : bubble, consumed without producing a result
//   flush               : abort in-flight op and drop the pending result
//   out_valid/out_ready : result handshake
//   result              : registered result, stable while stalled
//   busy                : iterative op in progress (MUL/DIV/FIN)
module alu_md_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter bit MD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            nop,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    md_ctx_t         ctx_q;
    logic [XLEN-1:0] a_raw_q;

    alu_op_e         op_e;
    logic            accept, md_go, md_start, md_step;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res, md_res;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [SW-1:0]   md_cnt;
    logic [XLEN-1:0] nxt_hi, nxt_lo;
    logic [2*XLEN-1:0] prod;

    assign op_e     = alu_op_e'(op);
    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_go    = MD_EN && op[3];
    assign md_start = accept && !nop && md_go && !flush;
    assign md_step  = ((state_q == MUL) || (state_q == DIV)) && !flush;
    assign busy     = (state_q != IDLE);
    assign shamt    = operand2[SW-1:0];

    // single-cycle ALU; md ops land here only when MD_EN=0 and yield 0
    always_comb begin
        alu_res = '0;
        case (op_e)
            OP_ADD:  alu_res = operand1 + operand2;
            OP_SLL:  alu_res = operand1 << shamt;
            OP_SUB:  alu_res = operand1 - operand2;
            OP_SRA:  alu_res = $signed(operand1) >>> shamt;
            OP_XOR:  alu_res = operand1 ^ operand2;
            OP_SRL:  alu_res = operand1 >> shamt;
            OP_OR:   alu_res = operand1 | operand2;
            OP_AND:  alu_res = operand1 & operand2;
            default: alu_res = '0;
        endcase
    end

    // iterative unit works on magnitudes; signs are reapplied in FIN
    assign a_neg = op_a_signed(op_e) && operand1[XLEN-1];
    assign b_neg = op_b_signed(op_e) && operand2[XLEN-1];
    assign a_mag = a_neg ? -operand1 : operand1;
    assign b_mag = b_neg ? -operand2 : operand2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_q   <= '0;
            a_raw_q <= '0;
        end else if (md_start) begin
            ctx_q.op    <= op_e;
            ctx_q.a_neg <= a_neg;
            ctx_q.b_neg <= b_neg;
            ctx_q.div0  <= (operand2 == '0);
            ctx_q.ovf   <= ((op_e == OP_DIV) || (op_e == OP_REM)) &&
                           (operand1 == MINV) && (&operand2);
            a_raw_q     <= operand1;
        end
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .step   (md_step),
        .is_div (ctx_q.op[2]),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .cnt    (md_cnt),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    // FIN takes the final iteration combinationally and applies sign fixup,
    // giving accept + (XLEN-1) MUL/DIV cycles + FIN = XLEN+1 cycles total.
    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        md_res = '0;
        if (ctx_q.a_neg ^ ctx_q.b_neg) prod = -prod;
        case (ctx_q.op)
            OP_MUL:                        md_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  md_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (ctx_q.div0)                     md_res = '1;
                else if (ctx_q.ovf)                 md_res = MINV;
                else if (ctx_q.a_neg ^ ctx_q.b_neg) md_res = -nxt_lo;
                else                                md_res = nxt_lo;
            end
            OP_REM, OP_REMU: begin
                if (ctx_q.div0)       md_res = a_raw_q;
                else if (ctx_q.ovf)   md_res = '0;
                else if (ctx_q.a_neg) md_res = -nxt_hi;
                else                  md_res = nxt_hi;
            end
            default: md_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept && !nop && md_go) state_d = op[2] ? DIV : MUL;
                MUL, DIV: if (md_cnt == SW'(1)) state_d = FIN;
                FIN:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FIN and accept are exclusive (in_ready requires IDLE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (state_q == FIN) begin
            out_valid <= 1'b1;
            result    <= md_res;
        end else if (accept && !nop && !md_go) begin
            out_valid <= 1'b1;
            result    <= alu_res;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_md_seq.sv
module tb_alu_md_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, nop, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [31:0] operand1, operand2, result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_md_seq #(.XLEN(32), .MD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand1(operand1), .operand2(operand2), .nop(nop),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // single-cycle op: result must be valid right after the accepting edge
    task automatic do_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input string tag);
        op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check(tag, result, e);
    endtask

    // iterative op: count edges from accept until out_valid, expect 33
    task automatic do_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string tag);
        int n;
        op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd33);
        check(tag, result, e);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; in_valid = 1'b0; nop = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = 4'd0; operand1 = '0; operand2 = '0;
        #2;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result",    result,         32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // back-to-back single-cycle ops at full rate
        do_alu(OP_ADD, 32'd7,          32'd5, 32'h0000000C, "ADD");
        do_alu(OP_SUB, 32'd3,          32'd5, 32'hFFFFFFFE, "SUB");
        do_alu(OP_SRA, 32'h80000000,   32'd4, 32'hF8000000, "SRA");
        do_alu(OP_SRL, 32'h80000000,   32'd4, 32'h08000000, "SRL");
        do_alu(OP_SLL, 32'h00000003, 32'h21, 32'h00000006, "SLL shamt wrap");
        do_alu(OP_AND, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, "AND");
        tick();
        check("drain", 32'(out_valid), 32'd0);

        // iterative ops
        do_md(OP_MUL,   32'd6,        32'd7,        32'd42,        "MUL");
        do_md(OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  "MULH");
        do_md(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  "MULHU");
        do_md(OP_MULHSU,32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF,  "MULHSU");
        do_md(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  "DIV -7/2");
        do_md(OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  "REM -7/2");
        do_md(OP_DIVU,  32'd100,      32'd7,        32'd14,        "DIVU");
        do_md(OP_DIV,   32'd123,      32'd0,        32'hFFFFFFFF,  "DIV x/0");
        do_md(OP_REMU,  32'd123,      32'd0,        32'd123,       "REMU x/0");
        do_md(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000,  "DIV MIN/-1");
        do_md(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000,  "REM MIN/-1");
        tick();

        // output stall: result held, nothing accepted
        out_ready = 1'b0;
        do_alu(OP_ADD, 32'd1, 32'd2, 32'd3, "stall ADD");
        op = OP_SUB; operand1 = 32'd10; operand2 = 32'd4; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall valid",  32'(out_valid), 32'd1);
            check("stall result", result,         32'd3);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("release SUB", result, 32'd6);
        tick();
        check("release drain", 32'(out_valid), 32'd0);

        // flush in cycle 10 of a DIV
        op = OP_DIV; operand1 = 32'd1000; operand2 = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre-flush busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy",     32'(busy),      32'd0);
        check("flush valid",    32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready),  32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("flush no result", 32'(cnt), 32'd0);
        do_alu(OP_ADD, 32'd20, 32'd22, 32'd42, "post-flush ADD");

        // nop: accepted, no result raised
        nop = 1'b1; op = OP_ADD; operand1 = 32'd9; operand2 = 32'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; nop = 1'b0;
        check("nop valid",  32'(out_valid), 32'd0);
        check("nop result", result,         32'd42);
        check("nop busy",   32'(busy),      32'd0);

        // async reset mid-MUL
        op = OP_MUL; operand1 = 32'd3; operand2 = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid-MUL busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst busy",     32'(busy),      32'd0);
        check("arst valid",    32'(out_valid), 32'd0);
        check("arst result",   result,         32'd0);
        check("arst in_ready", 32'(in_ready),  32'd1);
        #1;
        rst_n = 1'b1;
        tick();
        do_alu(OP_OR, 32'h00F0, 32'h0F00, 32'h0FF0, "post-reset OR");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
